sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter WR_BURST_MAX, default 4, maximum consecutive write grants while any reader is pending.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ack out 1; these form the loader write requester.
REQ-007 SHALL have ports rd0_req in 1, rd0_addr in ADDR_W, rd0_ack out 1, rd0_valid out 1, rd0_data out DATA_W; these form the DDS table read requester.
REQ-008 SHALL have ports rd1_req, rd1_addr, rd1_ack, rd1_valid, rd1_data, with widths as rd0; these form the playback read requester.
REQ-009 SHALL have ports sram_wen out 1, sram_addr out ADDR_W, sram_wdata out DATA_W, sram_dout in DATA_W; these drive the single-port SRAM, which has one-cycle read latency.

Function
REQ-010 SHALL evaluate the requests at each rising edge and grant at most one requester per cycle.
REQ-011 SHALL register the grant: after edge N, the winner's ack is high for exactly one cycle and sram_addr/sram_wen/sram_wdata carry its command.
REQ-012 SHALL use this requester contract: hold req and address (and data) stable until ack; req held through ack counts as a new request.
REQ-013 SHALL give the writer priority over both readers, subject to REQ-014.
REQ-014 SHALL count consecutive write grants made while any rd*_req is high; when the count reaches WR_BURST_MAX, the next grant goes to a pending reader and the count clears.
REQ-015 SHALL clear the burst counter on any read grant or any cycle with no reader pending.
REQ-016 SHALL, for a write grant, drive sram_wen=1, sram_addr=wr_addr, sram_wdata=wr_data for that one cycle only.
REQ-017 SHALL, for a read grant, drive sram_wen=0 and sram_addr=rdX_addr; rdX_data is registered from sram_dout and rdX_valid pulses one cycle, two cycles after rdX_ack.
REQ-018 SHALL sustain one read per cycle; in-flight reads are tracked in a two-stage tag pipeline (valid bit plus reader id), so back-to-back reads to either reader return in issue order.
REQ-019 SHALL hold rdX_data until the next rdX_valid.
REQ-020 SHALL, when no grant is made, drive sram_wen=0 and keep sram_addr and sram_wdata at their last values.
REQ-021 SHALL never assert two acks in one cycle, and never assert sram_wen on a read grant.
REQ-022 SHALL, when wr_req and both read requests all rise in the same cycle with the burst counter at 0, grant the writer.

Reset
REQ-023 SHALL, while rst=1 at an edge, clear wr_ack, rd0_ack, rd1_ack, rd0_valid, rd1_valid and sram_wen to 0, and clear sram_addr, sram_wdata, rd0_data, rd1_data, the burst counter and the round-robin pointer to 0 (rd0 favoured next).
REQ-024 SHALL, on reset mid-operation, discard in-flight reads; no rdX_valid is issued for reads granted before reset.

Configuration
REQ-025 SHALL use macro SRAM_ARB_READ_RR_EN: when defined, contention between rd0 and rd1 uses round-robin; a pointer toggles to the other reader after each read grant.
REQ-026 SHALL, when SRAM_ARB_READ_RR_EN is undefined, always give rd0 priority over rd1; the pointer logic is absent.

Verification
REQ-027 SHALL cover: after reset, wr_req=1, addr=0x0010, data=0xBEEF -> wr_ack one cycle later with sram_wen=1, sram_addr=0x0010, sram_wdata=0xBEEF; then sram_wen=0.
REQ-028 SHALL cover: rd0 read of 0x0010 -> rd0_ack, then two cycles later rd0_valid=1 and rd0_data=0xBEEF; rd1_valid stays 0.
REQ-029 SHALL cover: wr_req and rd1_req held high for 10 cycles with WR_BURST_MAX=4 -> grant order W,W,W,W,R1,W,W,W,W,R1.
REQ-030 SHALL cover: rd0_req and rd1_req held high for 4 cycles -> with the macro defined, acks alternate rd0,rd1,rd0,rd1; without it, rd0 receives all 4 acks.
REQ-031 SHALL cover: alternating rd0/rd1 reads to 0x0001..0x0004 -> valids return in issue order with the matching data on the correct port.
REQ-032 SHALL cover: rst asserted one cycle after a rd1_ack -> no rd1_valid follows, and all outputs are at their reset values.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Three-requester arbiter in front of one single-port SRAM with a one-cycle
// read latency. The loader writer has priority over the two readers. While a
// reader waits, the writer may take at most WR_BURST_MAX grants in a row before
// a reader is forced in. Reads are pipelined, one per cycle. A two-stage tag
// pipeline routes each returning word to the reader that issued it.
//
// Grants are registered. Requests sampled at edge N produce the ack and the
// SRAM command right after edge N. The read word is captured from sram_dout
// at edge N+2, when rdX_valid pulses.
//
// Optional feature (macro SRAM_ARB_READ_RR_EN):
//   defined   -> rd0/rd1 contention resolved round-robin. The pointer favours
//                the reader that was not granted last.
//   undefined -> rd0 always wins over rd1; there is no pointer.
//
// Parameters:
//   ADDR_W        SRAM word-address width
//   DATA_W        SRAM data width
//   WR_BURST_MAX  max consecutive write grants while a reader is pending (>= 1)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data/wr_ack   loader write requester
//   rd0_req/rd0_addr/rd0_ack        DDS table read requester (command side)
//   rd0_valid/rd0_data              DDS table read return
//   rd1_*                           playback read requester, same shape as rd0
//   sram_wen/sram_addr/sram_wdata   SRAM command (registered)
//   sram_dout                       SRAM read data, valid one cycle after addr
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WR_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,

    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_ack,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,

    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_ack,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,

    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int               CNT_W       = $clog2(WR_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(WR_BURST_MAX);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD0,
        GNT_RD1
    } gnt_e;

    // One in-flight read: vld marks a real read, id selects the reader (1 = rd1).
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              wr_ack_q,     wr_ack_d;
    logic              rd0_ack_q,    rd0_ack_d;
    logic              rd1_ack_q,    rd1_ack_d;
    logic              sram_wen_q,   sram_wen_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [CNT_W-1:0]  burst_cnt_q,  burst_cnt_d;
    tag_t              tag0_q,       tag0_d;   // aligned with the SRAM command
    tag_t              tag1_q,       tag1_d;   // aligned with sram_dout
    logic              rd0_valid_q,  rd0_valid_d;
    logic              rd1_valid_q,  rd1_valid_d;
    logic [DATA_W-1:0] rd0_data_q,   rd0_data_d;
    logic [DATA_W-1:0] rd1_data_q,   rd1_data_d;

`ifdef SRAM_ARB_READ_RR_EN
    logic              rr_q,         rr_d;     // 1 = rd1 favoured next
`endif

    gnt_e gnt;
    logic any_rd;
    logic burst_full;
    logic pick_rd1;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // NOTE: every variable in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch to hold it.
    always_comb begin
        any_rd     = rd0_req | rd1_req;
        // Writer loses only when a reader waits and the burst is used up.
        burst_full = any_rd && (burst_cnt_q == BURST_LIMIT);

`ifdef SRAM_ARB_READ_RR_EN
        pick_rd1 = (rd0_req && rd1_req) ? rr_q : rd1_req;
`else
        pick_rd1 = !rd0_req;
`endif

        if (wr_req && !burst_full) begin
            gnt = GNT_WR;
        end else if (any_rd) begin
            gnt = pick_rd1 ? GNT_RD1 : GNT_RD0;
        end else begin
            gnt = GNT_NONE;
        end
    end

    // The counter only advances on writes that make a reader wait. A read
    // grant or a cycle with no reader pending starts the burst over.
    always_comb begin
        burst_cnt_d = '0;
        if (gnt == GNT_WR && any_rd) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

`ifdef SRAM_ARB_READ_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (gnt == GNT_RD0) begin
            rr_d = 1'b1;
        end else if (gnt == GNT_RD1) begin
            rr_d = 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // SRAM command and acks
    // ------------------------------------------------------------------------
    // Address and write data hold their last values when no grant is made.
    // This keeps the SRAM bus quiet between accesses.
    always_comb begin
        wr_ack_d     = (gnt == GNT_WR);
        rd0_ack_d    = (gnt == GNT_RD0);
        rd1_ack_d    = (gnt == GNT_RD1);
        sram_wen_d   = (gnt == GNT_WR);
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        case (gnt)
            GNT_WR: begin
                sram_addr_d  = wr_addr;
                sram_wdata_d = wr_data;
            end
            GNT_RD0: sram_addr_d = rd0_addr;
            GNT_RD1: sram_addr_d = rd1_addr;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read tag pipeline and return path
    // ------------------------------------------------------------------------
    // tag0 travels with the SRAM command. tag1 lines up with the cycle in
    // which sram_dout carries that read's word, so the word is captured on the
    // same edge that the valid is raised.
    always_comb begin
        tag0_d.vld = (gnt == GNT_RD0) || (gnt == GNT_RD1);
        tag0_d.id  = (gnt == GNT_RD1);
        tag1_d     = tag0_q;

        rd0_valid_d = tag1_q.vld && !tag1_q.id;
        rd1_valid_d = tag1_q.vld &&  tag1_q.id;

        rd0_data_d = rd0_valid_d ? sram_dout : rd0_data_q;
        rd1_data_d = rd1_valid_d ? sram_dout : rd1_data_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack_q     <= 1'b0;
            rd0_ack_q    <= 1'b0;
            rd1_ack_q    <= 1'b0;
            sram_wen_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            burst_cnt_q  <= '0;
            // NOTE: the tag valid bits must be reset even though they look
            // like pipeline data. Clearing them drops reads still in flight,
            // so no valid comes back for a read granted before the reset.
            tag0_q       <= '0;
            tag1_q       <= '0;
            rd0_valid_q  <= 1'b0;
            rd1_valid_q  <= 1'b0;
            rd0_data_q   <= '0;
            rd1_data_q   <= '0;
        end else begin
            wr_ack_q     <= wr_ack_d;
            rd0_ack_q    <= rd0_ack_d;
            rd1_ack_q    <= rd1_ack_d;
            sram_wen_q   <= sram_wen_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            burst_cnt_q  <= burst_cnt_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            rd0_valid_q  <= rd0_valid_d;
            rd1_valid_q  <= rd1_valid_d;
            rd0_data_q   <= rd0_data_d;
            rd1_data_q   <= rd1_data_d;
        end
    end

`ifdef SRAM_ARB_READ_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wr_ack     = wr_ack_q;
    assign rd0_ack    = rd0_ack_q;
    assign rd1_ack    = rd1_ack_q;
    assign rd0_valid  = rd0_valid_q;
    assign rd1_valid  = rd1_valid_q;
    assign rd0_data   = rd0_data_q;
    assign rd1_data   = rd1_data_q;
    assign sram_wen   = sram_wen_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Bench for sram_port_arbiter with a behavioural one-cycle-latency SRAM.
// Every grant and every read return is queued when its stimulus is driven.
// A negedge monitor pops and compares those entries as the DUT produces acks
// and valids.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

`ifdef SRAM_ARB_READ_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_W    = 2'd1;
    localparam logic [1:0] G_R0   = 2'd2;
    localparam logic [1:0] G_R1   = 2'd3;

    typedef struct packed {
        logic              port;   // 1 = rd1
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    logic              clk;
    logic              rst;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_ack;
    logic              rd0_valid;
    logic [DATA_W-1:0] rd0_data;
    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_ack;
    logic              rd1_valid;
    logic [DATA_W-1:0] rd1_data;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_dout;

    logic [DATA_W-1:0] sram_mem [0:255];   // the SRAM the DUT drives
    logic [DATA_W-1:0] ref_mem  [0:255];   // bench's expected contents

    logic [1:0] exp_gnt_q [$];
    rd_exp_t    exp_rd_q  [$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] mon_code;
    rd_exp_t    mon_obs;

    sram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WR_BURST_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd0_req   (rd0_req),
        .rd0_addr  (rd0_addr),
        .rd0_ack   (rd0_ack),
        .rd0_valid (rd0_valid),
        .rd0_data  (rd0_data),
        .rd1_req   (rd1_req),
        .rd1_addr  (rd1_addr),
        .rd1_ack   (rd1_ack),
        .rd1_valid (rd1_valid),
        .rd1_data  (rd1_data),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (sram_wen === 1'b1) sram_mem[sram_addr[7:0]] <= sram_wdata;
        sram_dout <= sram_mem[sram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        exp_gnt_q.push_back(G_W);
        ref_mem[addr[7:0]] = data;
    endtask

    task automatic exp_read(input logic port, input logic [ADDR_W-1:0] addr);
        exp_gnt_q.push_back(port ? G_R1 : G_R0);
        exp_rd_q.push_back({port, ref_mem[addr[7:0]]});
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_wr_ack"},     wr_ack,     0);
        check({pfx, "_rd0_ack"},    rd0_ack,    0);
        check({pfx, "_rd1_ack"},    rd1_ack,    0);
        check({pfx, "_rd0_valid"},  rd0_valid,  0);
        check({pfx, "_rd1_valid"},  rd1_valid,  0);
        check({pfx, "_sram_wen"},   sram_wen,   0);
        check({pfx, "_sram_addr"},  sram_addr,  0);
        check({pfx, "_sram_wdata"}, sram_wdata, 0);
        check({pfx, "_rd0_data"},   rd0_data,   0);
        check({pfx, "_rd1_data"},   rd1_data,   0);
    endtask

    // Monitor: grant order, read returns, and the one-ack / no-wen-on-read rules.
    always @(negedge clk) begin
        if (sram_wen === 1'b1) check("wen_only_with_wr_ack", wr_ack, 1);
        if ((wr_ack | rd0_ack | rd1_ack) === 1'b1) begin
            check("ack_onehot", $countones({wr_ack, rd0_ack, rd1_ack}), 1);
            mon_code = wr_ack ? G_W : (rd0_ack ? G_R0 : G_R1);
            if (exp_gnt_q.size() == 0) check("grant_unexpected", mon_code, G_NONE);
            else                       check("grant_order", mon_code, exp_gnt_q.pop_front());
        end
        if ((rd0_valid | rd1_valid) === 1'b1) begin
            check("valid_onehot", $countones({rd0_valid, rd1_valid}), 1);
            mon_obs = {rd1_valid, (rd1_valid ? rd1_data : rd0_data)};
            if (exp_rd_q.size() == 0) check("valid_unexpected", {rd1_valid, rd0_valid}, 0);
            else                      check("read_return", mon_obs, exp_rd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic p;
        rst = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd0_addr = '0;
        rd1_req = 1'b0; rd1_addr = '0;

        // Power-on reset.
        repeat (2) tick();
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Single write.
        wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hBEEF;
        exp_write(16'h0010, 16'hBEEF);
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        check("wr_ack_pulse",  wr_ack,     1);
        check("wr_wen",        sram_wen,   1);
        check("wr_addr",       sram_addr,  16'h0010);
        check("wr_wdata",      sram_wdata, 16'hBEEF);
        tick();
        @(negedge clk);
        check("wr_ack_drop",   wr_ack,     0);
        check("idle_wen",      sram_wen,   0);
        check("idle_addr_hold",  sram_addr,  16'h0010);
        check("idle_wdata_hold", sram_wdata, 16'hBEEF);

        // Single rd0 read of the word just written, with exact latency.
        rd0_req = 1'b1; rd0_addr = 16'h0010;
        exp_read(1'b0, 16'h0010);
        tick();
        rd0_req = 1'b0;
        @(negedge clk);
        check("rd0_ack",       rd0_ack,   1);
        check("rd_no_wen",     sram_wen,  0);
        check("rd_addr",       sram_addr, 16'h0010);
        tick();
        @(negedge clk);
        check("rd0_valid_early", rd0_valid, 0);
        tick();
        @(negedge clk);
        check("rd0_valid_lat2", rd0_valid, 1);
        check("rd0_data",       rd0_data,  16'hBEEF);
        check("rd1_valid_quiet", rd1_valid, 0);

        // Writer vs pending rd1 for 10 cycles: W,W,W,W,R1,W,W,W,W,R1.
        wr_req = 1'b1; wr_addr = 16'h0020; wr_data = 16'h1234;
        rd1_req = 1'b1; rd1_addr = 16'h0010;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) exp_write(16'h0020, 16'h1234);
            exp_read(1'b1, 16'h0010);
        end
        repeat (10) tick();
        wr_req = 1'b0; rd1_req = 1'b0;
        repeat (3) tick();

        // All three rise together with the burst counter at 0: writer first.
        wr_req = 1'b1; wr_addr = 16'h0021; wr_data = 16'h5555;
        rd0_req = 1'b1; rd0_addr = 16'h0020;
        rd1_req = 1'b1; rd1_addr = 16'h0010;
        exp_write(16'h0021, 16'h5555);
        tick();
        wr_req = 1'b0;
        exp_read(1'b0, 16'h0020);
        tick();
        rd0_req = 1'b0;
        exp_read(1'b1, 16'h0010);
        tick();
        rd1_req = 1'b0;
        repeat (3) tick();

        // Load 0x0001..0x0004 back to back.
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_addr = 16'(i + 1); wr_data = 16'(16'hA001 + i);
            exp_write(16'(i + 1), 16'(16'hA001 + i));
            tick();
        end
        wr_req = 1'b0;
        tick();

        // rd0 and rd1 contending for 4 cycles.
        rd0_req = 1'b1; rd0_addr = 16'h0001;
        rd1_req = 1'b1; rd1_addr = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            p = RR_EN ? i[0] : 1'b0;
            exp_read(p, p ? 16'h0002 : 16'h0001);
        end
        repeat (4) tick();
        rd0_req = 1'b0; rd1_req = 1'b0;
        repeat (3) tick();

        // Alternating back-to-back reads of 0x0001..0x0004.
        for (int i = 0; i < 4; i++) begin
            rd0_req = !i[0]; rd1_req = i[0];
            rd0_addr = 16'(i + 1); rd1_addr = 16'(i + 1);
            exp_read(i[0], 16'(i + 1));
            tick();
        end
        rd0_req = 1'b0; rd1_req = 1'b0;
        repeat (4) tick();

        // Reset one cycle after a rd1 ack: that read must never return.
        rd1_req = 1'b1; rd1_addr = 16'h0003;
        exp_gnt_q.push_back(G_R1);
        tick();
        rd1_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_rd1_ack", rd1_ack, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        tick();
        @(negedge clk);
        check("rst_no_rd1_valid_a", rd1_valid, 0);
        tick();
        @(negedge clk);
        check("rst_no_rd1_valid_b", rd1_valid, 0);

        repeat (4) tick();
        @(negedge clk);
        check("grant_queue_drained", exp_gnt_q.size(), 0);
        check("read_queue_drained",  exp_rd_q.size(),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
